// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Holds the line defaults, the serializer state encoding and the round-robin pick.
package uart_pkg;

  localparam int DIVISOR_9600       = 10416;
  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int MAX_REQ            = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // First set bit of valid at or after ptr, wrapping modulo num; 0 when none is set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                 input int ptr,
                                 input int num);
    int                 pick;
    int                 idx;
    logic               found;
    logic [MAX_REQ-1:0] sh;
    pick  = 0;
    found = 1'b0;
    for (int off = 0; off < MAX_REQ; off++) begin
      idx = (ptr + off) % num;
      sh  = valid >> idx;
      if (!found && (off < num) && sh[0]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit, DATA_WIDTH data bits LSB first, stop bit, each DIVISOR cycles.
// All outputs are registered and derived from the next state so they change with the state.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DIVISOR    = DIVISOR_9600,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(DIVISOR);
  localparam int BW = $clog2(DATA_WIDTH);

  tx_state_t             state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  bit_end;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    bit_end   = (count_q == CW'(DIVISOR - 1));

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (load) begin
          state_d   = S_START;
          bit_cnt_d = '0;
          shift_d   = load_data;
        end
      end
      S_START: begin
        count_d = bit_end ? '0 : count_q + 1'b1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        count_d = bit_end ? '0 : count_q + 1'b1;
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) state_d = S_STOP;
        end
      end
      S_STOP: begin
        count_d = bit_end ? '0 : count_q + 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    // Output levels follow the state being entered, so the line moves on the same edge.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP) && (count_d == CW'(DIVISOR - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART TX line between NUM_REQ byte producers.
// Handshake: a byte moves when req_valid[i] & req_ready[i]; req_ready is one-hot and only in idle.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DIVISOR    = DIVISOR_9600,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [GW-1:0]                 grant_id,
  output logic                          frame_done
);

  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [GW-1:0]         sel_idx;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    sel_idx    = GW'(rr_pick(MAX_REQ'(req_valid), int'(rr_ptr_q), NUM_REQ));
    // Reset gates the grant so req_ready stays low while rst_n_in is held.
    load       = (|req_valid) & ~busy & rst_n_in;
    load_data  = data_arr[sel_idx];
    req_ready  = load ? (NUM_REQ'(1) << sel_idx) : '0;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    if (load) begin
      grant_id_d = sel_idx;
      rr_ptr_d   = GW'((int'(sel_idx) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign grant_id = grant_id_q;

  uart_tx_serializer #(
    .DIVISOR    (DIVISOR),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .load       (load),
    .load_data  (load_data),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a frame-level reference model checked every cycle.
// Inputs change 1 ns after the rising edge; everything is observed on the falling edge.
module tb_uart_tx_scheduler;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int DIV   = 4;
  localparam int FRAME = (DW + 2) * DIV;

  logic             clk_in    = 1'b0;
  logic             rst_n_in  = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic [NR-1:0]    req_ready;
  logic             tx_out;
  logic             busy;
  logic [1:0]       grant_id;
  logic             frame_done;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  uart_tx_scheduler #(
    .NUM_REQ    (NR),
    .DIVISOR    (DIV),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a start offset k in 0..FRAME-1; bit k/DIV is start, data, or stop.
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_byte   = '0;
  int         m_gid    = 0;
  int         m_rr     = 0;
  int         m_bit;
  int         m_pick;
  logic       m_tx;

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      check("rst_tx", tx_out, 1);
      check("rst_busy", busy, 0);
      check("rst_ready", req_ready, 0);
      check("rst_gid", grant_id, 0);
      check("rst_done", frame_done, 0);
      m_active = 1'b0;
      m_k      = 0;
      m_gid    = 0;
      m_rr     = 0;
    end else if (m_active) begin
      m_bit = m_k / DIV;
      if (m_bit == 0)       m_tx = 1'b0;
      else if (m_bit <= DW) m_tx = m_byte[m_bit-1];
      else                  m_tx = 1'b1;
      check("mdl_tx", tx_out, m_tx);
      check("mdl_busy", busy, 1);
      check("mdl_done", frame_done, (m_k == FRAME - 1));
      check("mdl_ready_busy", req_ready, 0);
      check("mdl_gid", grant_id, m_gid);
      m_k++;
      if (m_k == FRAME) m_active = 1'b0;
    end else begin
      check("mdl_idle_tx", tx_out, 1);
      check("mdl_idle_busy", busy, 0);
      check("mdl_idle_done", frame_done, 0);
      check("mdl_gid", grant_id, m_gid);
      if (|req_valid) begin
        m_pick = 0;
        for (int off = NR - 1; off >= 0; off--)
          if (req_valid[(m_rr + off) % NR]) m_pick = (m_rr + off) % NR;
        check("mdl_ready", req_ready, 32'(1) << m_pick);
        m_active = 1'b1;
        m_k      = 0;
        m_byte   = req_data[m_pick*DW +: DW];
        m_gid    = m_pick;
        m_rr     = (m_pick + 1) % NR;
      end else begin
        check("mdl_ready_idle", req_ready, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n_in  = 1'b0;
    req_valid = '0;
    repeat (2) tick();
    rst_n_in = 1'b1;
  endtask

  task automatic wait_grant(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (|req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: req_ready never rose within 200 cycles", name);
    end
  endtask

  initial begin
    // Single byte 0x41 from requester 1.
    do_reset();
    req_data[15:8] = 8'h41;
    req_valid      = 4'b0010;
    @(negedge clk_in);
    check("t1_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    exp_q.delete();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(1);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk_in);
      if (k % DIV == 1) check("t1_tx_bit", tx_out, exp_q.pop_front());
      if (k == FRAME - 1) check("t1_done", frame_done, 1);
    end
    check("t1_gid", grant_id, 1);

    // Requesters 0 and 2 both valid out of reset.
    tick();
    rst_n_in  = 1'b0;
    req_valid = 4'b0101;
    req_data  = {8'h00, 8'h55, 8'h00, 8'hAA};
    repeat (2) tick();
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("t2_first_ready", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    repeat (FRAME - 1) tick();
    @(negedge clk_in);
    check("t2_ready_early", req_ready, 0);
    tick();
    @(negedge clk_in);
    check("t2_second_ready", req_ready, 4'b0100);
    check("t2_gap_tx", tx_out, 1);
    tick();
    req_valid = '0;
    @(negedge clk_in);
    check("t2_start_tx", tx_out, 0);
    check("t2_gid", grant_id, 2);
    repeat (FRAME) tick();

    // All four valid for six frames.
    do_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'hF;
    exp_q.delete();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    for (int f = 0; f < 6; f++) begin
      wait_grant("t3_grant");
      tick();
      @(negedge clk_in);
      check("t3_gid_seq", grant_id, exp_q.pop_front());
    end
    tick();
    req_valid = '0;
    repeat (FRAME) tick();

    // Requester 3 asks mid-frame, then requester 2 pulses while busy.
    do_reset();
    req_data[7:0] = 8'h3C;
    req_valid     = 4'b0001;
    wait_grant("t4_first");
    tick();
    req_valid = '0;
    repeat (10) tick();
    req_data[31:24] = 8'hC3;
    req_valid       = 4'b1000;
    @(negedge clk_in);
    check("t4_ready_busy", req_ready, 0);
    repeat (30) tick();
    @(negedge clk_in);
    check("t4_ready_idle", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    @(negedge clk_in);
    check("t4_gid", grant_id, 3);
    repeat (5) tick();
    req_data[23:16] = 8'hE7;
    req_valid       = 4'b0100;
    tick();
    req_valid = '0;
    repeat (FRAME) tick();
    @(negedge clk_in);
    check("t5_busy_after", busy, 0);
    repeat (10) tick();
    @(negedge clk_in);
    check("t5_tx_idle", tx_out, 1);
    check("t5_gid_held", grant_id, 3);

    // Reset during the data bits, then a clean frame for requester 3.
    do_reset();
    req_data[15:8] = 8'h5A;
    req_valid      = 4'b0010;
    wait_grant("t6_first");
    tick();
    req_valid = '0;
    repeat (16) tick();
    #2;
    rst_n_in = 1'b0;
    #1;
    check("t6_async_tx", tx_out, 1);
    check("t6_async_busy", busy, 0);
    repeat (2) tick();
    rst_n_in        = 1'b1;
    req_data[31:24] = 8'h96;
    req_valid       = 4'b1000;
    @(negedge clk_in);
    check("t6_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    @(negedge clk_in);
    check("t6_gid", grant_id, 3);
    check("t6_start_tx", tx_out, 0);
    repeat (FRAME + 5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
